// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: drives one 74181-style 4-bit ALU slice over an N-nibble operand,
// least-significant nibble first, threading the active-low ripple carry between nibbles.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic [3:0]             s,
  input  logic                   m,
  input  logic                   cin_n,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   f,
  output logic                   cout_n,
  output logic                   aeb,
  output logic [3:0]             slice_a,
  output logic [3:0]             slice_b,
  output logic [3:0]             slice_s,
  output logic                   slice_m,
  output logic                   slice_cn_n,
  input  logic [3:0]             slice_f,
  input  logic                   slice_cn4_n,
  input  logic                   slice_aeb
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_n_q, carry_n_d;
  logic             aeb_acc_q, aeb_acc_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [W-1:0]     f_q, f_d;
  logic             cout_n_q, cout_n_d;
  logic             aeb_q, aeb_d;

  logic [3:0]       nib_a, nib_b;
  logic             last_nib;

  // Explicit nibble mux so every legal NIBBLES value maps cleanly onto idx.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  assign last_nib = (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_n_d = carry_n_q;
    aeb_acc_d = aeb_acc_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    m_d       = m_q;
    f_d       = f_q;
    cout_n_d  = cout_n_q;
    aeb_d     = aeb_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          s_d       = s;
          m_d       = m;
          carry_n_d = cin_n;
          idx_d     = '0;
          aeb_acc_d = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            f_d[4*i +: 4] = slice_f;
          end
        end
        carry_n_d = slice_cn4_n;
        aeb_acc_d = aeb_acc_q & slice_aeb;
        if (last_nib) begin
          idx_d    = '0;
          cout_n_d = slice_cn4_n;
          aeb_d    = aeb_acc_q & slice_aeb;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_n_q <= 1'b1;
      aeb_acc_q <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      f_q       <= '0;
      cout_n_q  <= 1'b1;
      aeb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_n_q <= carry_n_d;
      aeb_acc_q <= aeb_acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      m_q       <= m_d;
      f_q       <= f_d;
      cout_n_q  <= cout_n_d;
      aeb_q     <= aeb_d;
    end
  end

  // Outside RUN the slice sees a quiet, carry-free input set.
  always_comb begin
    slice_a    = 4'h0;
    slice_b    = 4'h0;
    slice_s    = 4'h0;
    slice_m    = 1'b0;
    slice_cn_n = 1'b1;
    if (state_q == RUN) begin
      slice_a    = nib_a;
      slice_b    = nib_b;
      slice_s    = s_q;
      slice_m    = m_q;
      slice_cn_n = carry_n_q;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign f      = f_q;
  assign cout_n = cout_n_q;
  assign aeb    = aeb_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed vectors with a queue-based scoreboard; a behavioural
// 74181 slice model closes the loop around the sequencer.
module tb_alu_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i, b_i;
  logic [3:0]   s_i;
  logic         m_i, cin_n_i;
  logic         busy, done, cout_n, aeb;
  logic [W-1:0] f;
  logic [3:0]   slice_a, slice_b, slice_s, slice_f;
  logic         slice_m, slice_cn_n, slice_cn4_n, slice_aeb;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [95:0]  name;
    logic [W-1:0] f;
    logic         cout_n;
    logic         aeb;
    logic [W-1:0] sa;
    logic [3:0]   cn;
    int           dcyc;
  } exp_t;

  exp_t sb[$];

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .s(s_i), .m(m_i),
    .cin_n(cin_n_i), .busy(busy), .done(done), .f(f), .cout_n(cout_n), .aeb(aeb),
    .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s), .slice_m(slice_m),
    .slice_cn_n(slice_cn_n), .slice_f(slice_f), .slice_cn4_n(slice_cn4_n),
    .slice_aeb(slice_aeb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 74181 slice in active-high data convention.
  always_comb begin
    logic cy, pi, gi;
    cy      = ~slice_cn_n;
    slice_f = 4'h0;
    for (int i = 0; i < 4; i++) begin
      pi = ~(slice_a[i] | (slice_b[i] & slice_s[0]) | (~slice_b[i] & slice_s[1]));
      gi = ~((slice_a[i] & ~slice_b[i] & slice_s[2]) | (slice_a[i] & slice_b[i] & slice_s[3]));
      slice_f[i] = pi ^ gi ^ (slice_m | cy);
      cy = ~gi | (~pi & cy);
    end
    slice_cn4_n = ~cy;
    slice_aeb   = &slice_f;
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !done) ok = 1;
    end
    if (!ok) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [95:0] nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [3:0] sv, input logic mv, input logic cv,
                               input logic [W-1:0] ef, input logic ec, input logic ea,
                               input logic [3:0] ecn);
    exp_t e;
    waitIdle();
    @(posedge clk);
    #1;
    a_i = av; b_i = bv; s_i = sv; m_i = mv; cin_n_i = cv; start = 1'b1;
    e.name = nm; e.f = ef; e.cout_n = ec; e.aeb = ea; e.sa = av; e.cn = ecn;
    e.dcyc = cyc + N + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Monitor: records the slice stream during RUN and scores each done pulse.
  initial begin : monitor
    logic [W-1:0] run_sa;
    logic [3:0]   run_cn;
    int           run_n;
    exp_t         e;
    run_sa = '0;
    run_cn = '0;
    run_n  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_n = 0;
      end else if (busy && !done) begin
        if (run_n < N) begin
          run_sa[4*run_n +: 4] = slice_a;
          run_cn[run_n]        = slice_cn_n;
        end
        run_n++;
      end else if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("%0s_f", e.name), 32'(f), 32'(e.f));
          checkOutput($sformatf("%0s_cout_n", e.name), 32'(cout_n), 32'(e.cout_n));
          checkOutput($sformatf("%0s_aeb", e.name), 32'(aeb), 32'(e.aeb));
          checkOutput($sformatf("%0s_slice_a_seq", e.name), 32'(run_sa), 32'(e.sa));
          checkOutput($sformatf("%0s_slice_cn_seq", e.name), 32'(run_cn), 32'(e.cn));
          checkOutput($sformatf("%0s_run_cycles", e.name), 32'(run_n), 32'(N));
          checkOutput($sformatf("%0s_done_cycle", e.name), 32'(cyc), 32'(e.dcyc));
        end
        run_n = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int cnt;
    bit seen;
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; s_i = '0; m_i = 1'b0; cin_n_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_f", 32'(f), 0);
    checkOutput("rst_cout_n", 32'(cout_n), 1);
    checkOutput("rst_aeb", 32'(aeb), 0);
    checkOutput("rst_slice_cn_n", 32'(slice_cn_n), 1);
    checkOutput("rst_slice_a", 32'(slice_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus("add",     16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 16'h2201, 1'b1, 1'b0, 4'b0001);
    applyStimulus("ripple",  16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'b0001);
    applyStimulus("cmp_eq",  16'hA5A5, 16'hA5A5, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 4'b1111);
    applyStimulus("cmp_ne",  16'hA5A5, 16'hA5A4, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'b0001);
    applyStimulus("xor",     16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0, 4'b1011);

    // Idle: result holds and slice stays quiet whatever the inputs do.
    waitIdle();
    a_i = 16'hFFFF; b_i = 16'hFFFF; s_i = 4'hF; m_i = 1'b1; cin_n_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_f_hold", 32'(f), 32'h0FF0);
    checkOutput("idle_slice_a", 32'(slice_a), 0);
    checkOutput("idle_slice_s", 32'(slice_s), 0);
    checkOutput("idle_slice_cn_n", 32'(slice_cn_n), 1);
    checkOutput("idle_busy", 32'(busy), 0);

    // Starts during RUN and during DONE must be dropped.
    applyStimulus("busy_add", 16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 16'h2201, 1'b1, 1'b0, 4'b0001);
    @(posedge clk);
    #1;
    a_i = 16'hFFFF; b_i = 16'h0001; cin_n_i = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) checkOutput("busy_done_timeout", 0, 1);
    start = 1'b1; a_i = 16'h0F0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    checkOutput("ignored_start_busy", 32'(cnt), 0);
    checkOutput("ignored_start_f", 32'(f), 32'h2201);

    // Reset in the second RUN cycle aborts without a done pulse.
    applyStimulus("aborted", 16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 16'h2201, 1'b1, 1'b0, 4'b0001);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_f", 32'(f), 0);
    checkOutput("abort_cout_n", 32'(cout_n), 1);
    checkOutput("abort_slice_cn_n", 32'(slice_cn_n), 1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checkOutput("abort_no_done", 32'(cnt), 0);

    applyStimulus("fresh", 16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, 16'h1010, 1'b1, 1'b0, 4'b0101);

    waitIdle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput($sformatf("%0s_never_done", e.name), 0, 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
